term_char_writer: RTL

Terminal write controller sitting directly upstream of the character-buffer initializer and beside it on the character RAM write port. It accepts 7-bit character codes from the keyboard or CPU path and keeps the text cursor. Printable codes are written straight into the character RAM. Control codes move the cursor or request clears from the initializer, and the controller waits for each clear to finish before accepting more input.

---
 rtl/term_char_writer_if.sv | 27 ++
 rtl/term_char_writer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/term_char_writer_if.sv
// term_char_writer_if: character input, character RAM write port and initializer handshake
interface term_char_writer_if;
    logic        charValid;
    logic [6:0]  charIn;
    logic        charReady;
    logic        wrEn;
    logic [11:0] wrAddress;
    logic [6:0]  wrData;
    logic [4:0]  cursorRow;
    logic [6:0]  cursorCol;
    logic        initEnable;
    logic        initRowOnly;
    logic [4:0]  initRow;
    logic [6:0]  initCol;
    logic        initSequential;
    logic        initBusy;
    modport master (
        input  charValid, charIn, initBusy,
        output charReady, wrEn, wrAddress, wrData, cursorRow, cursorCol,
               initEnable, initRowOnly, initRow, initCol, initSequential
    );
    modport slave (
        output charValid, charIn, initBusy,
        input  charReady, wrEn, wrAddress, wrData, cursorRow, cursorCol,
               initEnable, initRowOnly, initRow, initCol, initSequential
    );
endinterface

// File: rtl/term_char_writer.sv
// term_char_writer: writes printable characters, tracks the cursor and sequences initializer clears
module term_char_writer #(
    parameter int MAXCOL             = 80,
    parameter int MAXROW             = 32,
    parameter int POWERUP_CLEAR      = 1,
    parameter int INIT_START_TIMEOUT = 8
) (
    input logic clk,
    input logic resetn,
    term_char_writer_if.master bus
);
    typedef enum logic [1:0] {IDLE, INIT_REQ, WAIT_START, WAIT_DONE} state_t;
    localparam int CW = $clog2(INIT_START_TIMEOUT + 1);
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [4:0] row, row_n, i_row, i_row_n, row_inc;
    logic [6:0] col, col_n, i_col, i_col_n, wr_data, wr_data_n;
    logic [11:0] wr_addr, wr_addr_n;
    logic [7:0] tab;
    logic i_ronly, i_ronly_n, i_seq, i_seq_n, wr_en, wr_en_n;
    logic accept, printable, req, req_ronly, req_seq;
    logic [4:0] req_row;
    logic [6:0] req_col;
    assign accept    = bus.charValid && state == IDLE;
    assign printable = bus.charIn >= 7'h20 && bus.charIn <= 7'h7E;
    assign row_inc   = (row == 5'(MAXROW - 1)) ? 5'd0 : row + 5'd1;
    assign tab       = {1'b0, col | 7'd7} + 8'd1;
    always_comb begin
        state_n   = state;
        cnt_n     = '0;
        row_n     = row;
        col_n     = col;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        req       = 1'b0;
        req_ronly = 1'b0;
        req_seq   = 1'b0;
        req_row   = 5'd0;
        req_col   = 7'd0;
        case (state)
            IDLE: if (accept) begin
                if (printable) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = {col, row};
                    wr_data_n = bus.charIn;
                    col_n     = (col == 7'(MAXCOL - 1)) ? 7'd0 : col + 7'd1;
                    row_n     = (col == 7'(MAXCOL - 1)) ? row_inc : row;
                    req       = col == 7'(MAXCOL - 1);
                    req_ronly = 1'b1;
                    req_row   = row_inc;
                end else begin
                    case (bus.charIn)
                        7'h0D: col_n = 7'd0;
                        7'h0A: begin
                            row_n     = row_inc;
                            req       = 1'b1;
                            req_ronly = 1'b1;
                            req_row   = row_inc;
                        end
                        7'h08: col_n = (col != 7'd0) ? col - 7'd1 : col;
                        7'h09: col_n = (tab > 8'(MAXCOL - 1)) ? 7'(MAXCOL - 1) : tab[6:0];
                        7'h0C, 7'h0E: begin
                            row_n   = 5'd0;
                            col_n   = 7'd0;
                            req     = 1'b1;
                            req_seq = bus.charIn == 7'h0E;
                        end
                        7'h18: begin
                            req       = 1'b1;
                            req_ronly = 1'b1;
                            req_row   = row;
                            req_col   = col;
                        end
                        default: ;
                    endcase
                end
            end
            INIT_REQ: state_n = WAIT_START;
            WAIT_START: begin
                state_n = bus.initBusy ? WAIT_DONE :
                          (cnt == CW'(INIT_START_TIMEOUT - 1)) ? IDLE : WAIT_START;
                cnt_n   = cnt + 1'b1;
            end
            WAIT_DONE: state_n = bus.initBusy ? WAIT_DONE : IDLE;
            default: state_n = IDLE;
        endcase
        // request fields only change when a new clear is launched, so they stay stable until IDLE
        state_n   = req ? INIT_REQ : state_n;
        i_ronly_n = req ? req_ronly : i_ronly;
        i_seq_n   = req ? req_seq : i_seq;
        i_row_n   = req ? req_row : i_row;
        i_col_n   = req ? req_col : i_col;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= (POWERUP_CLEAR != 0) ? INIT_REQ : IDLE;
            cnt     <= '0;
            row     <= 5'd0;
            col     <= 7'd0;
            wr_en   <= 1'b0;
            wr_addr <= 12'd0;
            wr_data <= 7'd0;
            i_ronly <= 1'b0;
            i_seq   <= 1'b0;
            i_row   <= 5'd0;
            i_col   <= 7'd0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            row     <= row_n;
            col     <= col_n;
            wr_en   <= wr_en_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
            i_ronly <= i_ronly_n;
            i_seq   <= i_seq_n;
            i_row   <= i_row_n;
            i_col   <= i_col_n;
        end
    end
    // gated by resetn so the strobe idles high while reset is held, even in the power-up INIT_REQ state
    assign bus.initEnable     = !(resetn && state == INIT_REQ);
    assign bus.charReady      = state == IDLE;
    assign bus.wrEn           = wr_en;
    assign bus.wrAddress      = wr_addr;
    assign bus.wrData         = wr_data;
    assign bus.cursorRow      = row;
    assign bus.cursorCol      = col;
    assign bus.initRowOnly    = i_ronly;
    assign bus.initRow        = i_row;
    assign bus.initCol        = i_col;
    assign bus.initSequential = i_seq;
endmodule
